// File: rtl/pipe_stage_regs.sv
// -----------------------------------------------------------------------------
// pipe_stage_regs
//
// Pipeline state for the front half of the 5-stage RV32I core. It holds the
// fetch PC, the IF/ID register and the ID/EX register, and applies the stall
// and flush requests raised by the hazard unit and the branch logic.
//
// Optional build macro: PIPE_PERF_CNT_EN
//   When defined, two saturating 32-bit performance counters are added:
//   StallCnt (edges with StallD) and FlushCnt (edges with FlushD or FlushE).
//   When undefined, those ports and the counter logic are absent.
//
// Parameters
//   RESET_PC : PC value loaded on reset
//   CTRL_W   : width of the packed decode control word (all-zero word = NOP)
//              bits [1:0] ResultSrc, bit 2 RegWrite
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   StallF, StallD                hold PCF / hold IF/ID
//   FlushD, FlushE                bubble IF/ID / bubble ID/EX
//   PCNextF, InstrF, PCPlus4F     fetch-stage inputs
//   CtrlD, RD1D, RD2D, ImmExtD    decode-stage inputs
//   PCF                           current fetch PC
//   InstrD, PCD, PCPlus4D, ValidD IF/ID contents
//   CtrlE, RD1E, RD2E, ImmExtE,
//   PCE, PCPlus4E, ValidE         ID/EX contents
//   Rs1E, Rs2E, RdE               register specifiers captured from InstrD
//   ResultSrcE                    CtrlE[1:0], the only combinational output
//   StallCnt, FlushCnt            performance counters (PIPE_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CTRL_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       PCNextF,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic [31:0]       RD1D,
  input  logic [31:0]       RD2D,
  input  logic [31:0]       ImmExtD,
  output logic [31:0]       PCF,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic              ValidE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic [31:0]       RD1E,
  output logic [31:0]       RD2E,
  output logic [31:0]       ImmExtE,
  output logic [31:0]       PCE,
  output logic [31:0]       PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic [1:0]        ResultSrcE
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  // ---------------------------------------------------------------------------
  // Fetch PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      PCF <= RESET_PC;
    end else if (!StallF) begin
      PCF <= PCNextF;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register: reset > FlushD > StallD > load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || FlushD) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX register: reset > FlushE > load
  // There is deliberately no stall term here. The hazard unit pairs StallD
  // with FlushE, and if it ever does not, ID/EX simply loads again.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      CtrlE    <= '0;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      RdE      <= '0;
      ValidE   <= 1'b0;
    end else begin
      CtrlE    <= CtrlD;
      RD1E     <= RD1D;
      RD2E     <= RD2D;
      ImmExtE  <= ImmExtD;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
      Rs1E     <= InstrD[19:15];
      Rs2E     <= InstrD[24:20];
      RdE      <= InstrD[11:7];
      ValidE   <= ValidD;
    end
  end

  // Hazard unit compares against this every cycle, so it is a plain wire.
  assign ResultSrcE = CtrlE[1:0];

`ifdef PIPE_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones
  // ---------------------------------------------------------------------------
  logic [31:0] stallCntQ;
  logic [31:0] flushCntQ;
  logic        stallSat;
  logic        flushSat;

  assign stallSat = &stallCntQ;
  assign flushSat = &flushCntQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntQ <= '0;
    end else if (StallD && !stallSat) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  // A cycle with both flushes asserted counts as one flush event.
  always_ff @(posedge clk) begin
    if (reset) begin
      flushCntQ <= '0;
    end else if ((FlushD || FlushE) && !flushSat) begin
      flushCntQ <= flushCntQ + 32'd1;
    end
  end

  assign StallCnt = stallCntQ;
  assign FlushCnt = flushCntQ;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] I1  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I2  = 32'h0020_8133; // add  x2,x1,x2
  localparam logic [31:0] I3  = 32'h0031_0193; // addi x3,x2,3

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, FlushE;
  logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, ImmExtD;
  logic [11:0] CtrlD;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, ValidE;
  logic [11:0] CtrlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [1:0]  ResultSrcE;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  pipe_stage_regs #(.RESET_PC(RPC), .CTRL_W(12)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF),
    .PCPlus4F(PCPlus4F), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCF(PCF), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD), .ValidE(ValidE), .CtrlE(CtrlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE)
`ifdef PIPE_PERF_CNT_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcF, instrD, pcD, rd1E;
    logic        vD, vE;
    logic [4:0]  rdE, rs2E;
    logic [11:0] ctrlE;
  } exp_t;

  typedef struct {
    logic        rst, sF, sD, fD, fE;
    logic [31:0] pcNext, instr, rd1;
    logic [11:0] ctrl;
    exp_t        e;
  } vec_t;

  vec_t vecs[12];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic rst, logic sF, logic sD, logic fD, logic fE,
                              logic [31:0] pcNext, logic [31:0] instr,
                              logic [11:0] ctrl, logic [31:0] rd1,
                              logic [31:0] ePcF, logic [31:0] eInstrD,
                              logic [31:0] ePcD, logic eVD, logic eVE,
                              logic [4:0] eRdE, logic [4:0] eRs2E,
                              logic [11:0] eCtrlE, logic [31:0] eRd1E);
    vec_t v;
    v.rst = rst; v.sF = sF; v.sD = sD; v.fD = fD; v.fE = fE;
    v.pcNext = pcNext; v.instr = instr; v.ctrl = ctrl; v.rd1 = rd1;
    v.e.pcF = ePcF; v.e.instrD = eInstrD; v.e.pcD = ePcD;
    v.e.vD = eVD; v.e.vE = eVE; v.e.rdE = eRdE; v.e.rs2E = eRs2E;
    v.e.ctrlE = eCtrlE; v.e.rd1E = eRd1E;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic sF, input logic sD,
                       input logic fD, input logic fE);
    reset = rst; StallF = sF; StallD = sD; FlushD = fD; FlushE = fE;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    PCNextF = '0; InstrF = '0; PCPlus4F = '0; CtrlD = '0;
    RD1D = '0; RD2D = '0; ImmExtD = '0;

    //             rst sF sD fD fE  pcNext   instr ctrl    rd1     | pcF      instrD pcD      vD vE rdE rs2E ctrlE   rd1E
    vecs[0]  = mk(1, 0, 0, 0, 0, 32'h104, I1, 12'h000, 32'h00, RPC,     32'h0, 32'h000, 0, 0, 0, 0, 12'h000, 32'h00);
    vecs[1]  = mk(1, 0, 0, 0, 0, 32'h104, I1, 12'h000, 32'h00, RPC,     32'h0, 32'h000, 0, 0, 0, 0, 12'h000, 32'h00);
    vecs[2]  = mk(0, 0, 0, 0, 0, 32'h104, I1, 12'h000, 32'h00, 32'h104, I1,    32'h100, 1, 0, 0, 0, 12'h000, 32'h00);
    vecs[3]  = mk(0, 0, 0, 0, 0, 32'h108, I2, 12'h004, 32'h11, 32'h108, I2,    32'h104, 1, 1, 1, 5, 12'h004, 32'h11);
    // load-use: PC and IF/ID hold, EX bubble
    vecs[4]  = mk(0, 1, 1, 0, 1, 32'h10C, I3, 12'h006, 32'h22, 32'h108, I2,    32'h104, 1, 0, 0, 0, 12'h000, 32'h00);
    vecs[5]  = mk(0, 0, 0, 0, 0, 32'h10C, I3, 12'h006, 32'h22, 32'h10C, I3,    32'h108, 1, 1, 2, 2, 12'h006, 32'h22);
    // branch flush with StallD: flush wins
    vecs[6]  = mk(0, 0, 1, 1, 1, 32'h200, I1, 12'h005, 32'h33, 32'h200, 32'h0, 32'h000, 0, 0, 0, 0, 12'h000, 32'h00);
    vecs[7]  = mk(0, 0, 0, 0, 0, 32'h204, I2, 12'h000, 32'h00, 32'h204, I2,    32'h200, 1, 0, 0, 0, 12'h000, 32'h00);
    // StallD without FlushE: ID/EX still loads
    vecs[8]  = mk(0, 1, 1, 0, 0, 32'h208, I3, 12'h006, 32'h44, 32'h204, I2,    32'h200, 1, 1, 2, 2, 12'h006, 32'h44);
    // reset in the middle of a stall
    vecs[9]  = mk(1, 1, 1, 0, 0, 32'h208, I3, 12'h006, 32'h44, RPC,     32'h0, 32'h000, 0, 0, 0, 0, 12'h000, 32'h00);
    vecs[10] = mk(0, 1, 1, 0, 1, 32'h104, I1, 12'h000, 32'h00, RPC,     32'h0, 32'h000, 0, 0, 0, 0, 12'h000, 32'h00);
    vecs[11] = mk(0, 0, 0, 0, 0, 32'h104, I1, 12'h000, 32'h00, 32'h104, I1,    32'h100, 1, 0, 0, 0, 12'h000, 32'h00);

    for (int i = 0; i < 12; i++) begin
      exp_t e;
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].sF, vecs[i].sD, vecs[i].fD, vecs[i].fE);
      PCNextF = vecs[i].pcNext; InstrF = vecs[i].instr; PCPlus4F = vecs[i].pcNext;
      CtrlD = vecs[i].ctrl; RD1D = vecs[i].rd1;
      sbq.push_back(vecs[i].e);
      @(posedge clk); #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_PCF", i), PCF, e.pcF);
      chk($sformatf("v%0d_InstrD", i), InstrD, e.instrD);
      chk($sformatf("v%0d_PCD", i), PCD, e.pcD);
      chk($sformatf("v%0d_ValidD", i), {31'b0, ValidD}, {31'b0, e.vD});
      chk($sformatf("v%0d_ValidE", i), {31'b0, ValidE}, {31'b0, e.vE});
      chk($sformatf("v%0d_RdE", i), {27'b0, RdE}, {27'b0, e.rdE});
      chk($sformatf("v%0d_Rs2E", i), {27'b0, Rs2E}, {27'b0, e.rs2E});
      chk($sformatf("v%0d_CtrlE", i), {20'b0, CtrlE}, {20'b0, e.ctrlE});
      chk($sformatf("v%0d_ResultSrcE", i), {30'b0, ResultSrcE}, {30'b0, e.ctrlE[1:0]});
      chk($sformatf("v%0d_RD1E", i), RD1E, e.rd1E);
    end
    chk("scoreboard_empty", sbq.size(), 32'd0);

    // Hand sequence: PC/operand carry-through into EX, then an EX bubble.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    PCNextF = 32'h104; InstrF = I3; PCPlus4F = 32'h104; CtrlD = '0;
    RD1D = '0; RD2D = '0; ImmExtD = '0;
    @(negedge clk);
    chk("seq_PCPlus4D", PCPlus4D, 32'h104);
    chk("seq_Rs1E_pre", {27'b0, Rs1E}, 32'd0);
    PCNextF = 32'h108; PCPlus4F = 32'h108;
    CtrlD = 12'h004; RD2D = 32'h55; ImmExtD = 32'hABC;
    @(negedge clk);
    chk("seq_PCE", PCE, 32'h100);
    chk("seq_PCPlus4E", PCPlus4E, 32'h104);
    chk("seq_RD2E", RD2E, 32'h55);
    chk("seq_ImmExtE", ImmExtE, 32'hABC);
    chk("seq_Rs1E", {27'b0, Rs1E}, 32'd2);
    chk("seq_RdE", {27'b0, RdE}, 32'd3);
    FlushE = 1'b1;
    @(negedge clk);
    chk("seq_flushE_PCE", PCE, 32'h0);
    chk("seq_flushE_ImmExtE", ImmExtE, 32'h0);
    chk("seq_flushE_Rs1E", {27'b0, Rs1E}, 32'd0);
    chk("seq_flushE_ValidE", {31'b0, ValidE}, 32'd0);
    chk("seq_flushE_ValidD", {31'b0, ValidD}, 32'd1);

`ifdef PIPE_PERF_CNT_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt_reset_stall", StallCnt, 32'd0);
    chk("cnt_reset_flush", FlushCnt, 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt_stall3", StallCnt, 32'd3);
    chk("cnt_flush0", FlushCnt, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cnt_flush1", FlushCnt, 32'd1);
    force dut.stallCntQ = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.stallCntQ;
    StallD = 1'b1;
    repeat (2) @(negedge clk);
    StallD = 1'b0;
    chk("cnt_stall_sat", StallCnt, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cnt_sat_reset", StallCnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
